slap_video_mixer: RTL and testbench
===================================

Name: slap_video_mixer

Overview:
- Downstream consumer of the background layer's 8-bit pixel output (palette[7:4], pen[3:0]).
- Merges it with the foreground/text and sprite layer pixels by fixed priority, aligns the layers with a configurable BG delay line, and maps the winning 8-bit colour index through three downloadable 256x4 colour PROMs (R, G, B).
- Drives the final 4:4:4 RGB with blanking to the video output stage.
- Everything advances on a pixel enable in the master clock domain. No second clock.

Parameters:
- BG_DELAY, 2: pixel strobes of extra delay applied to the BG pixel to align it with FG/sprite (legal 0..7).
- PROM_AW, 8: colour PROM address width (256 entries).

Ports:
- master_clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- pixel_ce  in  1  one-master_clk-wide pixel strobe; pipeline advances only when high.
- bg_pix  in  8  background pixel {palette[3:0], pen[3:0]}.
- fg_pix  in  8  foreground/text pixel {colour[5:0], pen[1:0]}.
- spr_pix  in  8  sprite pixel {palette[3:0], pen[3:0]}.
- hblank  in  1  horizontal blank, aligned with fg_pix/spr_pix.
- vblank  in  1  vertical blank, aligned with fg_pix/spr_pix.
- layer_en  in  3  {fg, spr, bg} enables; 0 forces that layer transparent.
- dn_addr  in  25  download address; bits [7:0] used.
- dn_data  in  8  download data; bits [3:0] used.
- dn_wr  in  1  download write strobe.
- prom_r_cs, prom_g_cs, prom_b_cs  in  1 each  PROM download selects.
- red, green, blue  out  4 each  final colour.
- blank_out  out  1  delayed hblank|vblank.

Behaviour:
- Reset (reset_n=0 at a master_clk edge):
  - red/green/blue=0, blank_out=1.
  - BG delay line, all pipeline registers and delayed blanks cleared.
  - Pipeline blank flags are forced to 1, so no pixel escapes for 2 strobes after reset release.
  - PROM contents are NOT cleared.
- Pipeline state changes only on edges where pixel_ce=1. With pixel_ce=0 everything holds; PROM download writes are the exception.
- BG delay: bg_pix passes through a BG_DELAY-deep shift register clocked by pixel_ce. BG_DELAY=0 means a direct path.
- Stage S1, strobe k: register the delayed bg, fg_pix, spr_pix, and blank = hblank|vblank.
- Stage S2, strobe k+1: select the colour index.
  - Transparency rules:
    - FG is transparent if pen[1:0]==0 or layer_en[2]=0.
    - Sprite is transparent if pen[3:0]==0 or layer_en[1]=0.
    - BG is never transparent. If layer_en[0]=0, its index is 8'h00.
  - Priority: FG opaque -> fg_pix; else sprite opaque -> spr_pix; else BG.
  - The index is the selected 8-bit value unchanged.
- Stage S3, strobe k+2: PROM synchronous read at the S2 index; red/green/blue <= PROM data.
  - If the S2 blank flag is 1, RGB is forced to 0.
  - blank_out <= S2 blank flag.
- Latency: inputs sampled at strobe k appear on the outputs after strobe k+2.
  - BG contribution is from strobe k-BG_DELAY.
- PROM download:
  - Write on any master_clk edge with dn_wr=1 and the matching cs; address dn_addr[7:0], data dn_data[3:0].
  - Writes are independent of pixel_ce.
  - Multiple cs high: all selected PROMs are written.
  - A same-cycle read and write to one address returns the old data (read-before-write).
- Reset mid-frame: pipeline is flushed as above. The first valid pixel appears 2 strobes after release.

Decomposition:
- Package slap_video_pkg holds:
  - layer_en bit positions (LAYER_FG=2, LAYER_SPR=1, LAYER_BG=0);
  - pen-field widths (FG_PEN_W=2, SPR_PEN_W=4);
  - pixel width 8;
  - MIX_LATENCY=2.
- One sub-module, colour_prom_256x4: single-port sync-read / sync-write RAM with download port, instantiated three times (R, G, B).

Test Plan:
- Priority, BG_DELAY=0, all layers enabled, PROMs loaded with R=addr[3:0], G=addr[7:4], B=~addr[3:0]:
  - bg=8'h35, spr=8'h00, fg=8'h00 -> after 2 strobes RGB={5,3,A}.
  - Then spr=8'h47 -> RGB={7,4,8}.
  - Then fg=8'h91 -> RGB={1,9,E}.
- Transparency/enable:
  - fg=8'hFC (pen 0) over spr=8'h12 -> index 12.
  - layer_en=3'b110 with both fg and spr transparent -> index 00 -> RGB={0,0,F}.
- BG_DELAY=3: bg ramp 0x01,0x02,... one value per strobe, fg/spr transparent -> output index at strobe n equals the bg value presented at strobe n-5.
- Blanking: hblank=1 for one pixel inside an opaque run -> blank_out=1 and RGB=0 exactly 2 strobes later, for exactly one strobe.
- pixel_ce gap / download:
  - Hold pixel_ce=0 for 10 clocks -> outputs stable.
  - Meanwhile write prom_r addr 0x35 data 0xC -> next displayed bg=0x35 gives red=C.
- Reset mid-run: assert reset_n=0 for 1 clock -> RGB=0 and blank_out=1 the next cycle; PROM contents retained (re-check index 0x35 -> red=C).

Source files
------------

// File: rtl/slap_video_pkg.sv
// slap_video_pkg: shared widths, layer-enable bit positions and the layer priority rule
// for the video mixer.
package slap_video_pkg;
    localparam int PIX_W       = 8;
    localparam int COL_W       = 4;
    localparam int LAYER_FG    = 2;
    localparam int LAYER_SPR   = 1;
    localparam int LAYER_BG    = 0;
    localparam int FG_PEN_W    = 2;
    localparam int SPR_PEN_W   = 4;
    localparam int MIX_LATENCY = 2;

    typedef logic [PIX_W-1:0] pix_t;

    // Pen 0 marks a transparent pixel; a disabled BG collapses to colour index 0.
    function automatic pix_t mix_index(pix_t bg, pix_t fg, pix_t spr, logic [2:0] en);
        return (en[LAYER_FG] && fg[FG_PEN_W-1:0] != '0)    ? fg  :
               (en[LAYER_SPR] && spr[SPR_PEN_W-1:0] != '0) ? spr :
               en[LAYER_BG]                                ? bg  : '0;
    endfunction
endpackage

// File: rtl/colour_prom_256x4.sv
// colour_prom_256x4: downloadable colour PROM, synchronous read gated by a read enable and
// an independent synchronous download write; a colliding read returns the old data.
module colour_prom_256x4
    import slap_video_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [COL_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [COL_W-1:0] rdata_o
);
    logic [COL_W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/slap_video_mixer.sv
// slap_video_mixer: aligns BG to FG/sprite, picks the winning colour index by layer
// priority and maps it through three downloadable colour PROMs to blanked RGB.
module slap_video_mixer
    import slap_video_pkg::*;
#(
    parameter int BG_DELAY = 2,
    parameter int PROM_AW  = 8
) (
    input  logic             master_clk,
    input  logic             reset_n,
    input  logic             pixel_ce,
    input  logic [PIX_W-1:0] bg_pix,
    input  logic [PIX_W-1:0] fg_pix,
    input  logic [PIX_W-1:0] spr_pix,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [2:0]       layer_en,
    input  logic [24:0]      dn_addr,
    input  logic [7:0]       dn_data,
    input  logic             dn_wr,
    input  logic             prom_r_cs,
    input  logic             prom_g_cs,
    input  logic             prom_b_cs,
    output logic [COL_W-1:0] red,
    output logic [COL_W-1:0] green,
    output logic [COL_W-1:0] blue,
    output logic             blank_out
);
    pix_t bg_dly, bg_q, fg_q, spr_q, idx_q, idx_d;
    logic [MIX_LATENCY-1:0] blank_q;
    logic blank_out_q;
    logic [COL_W-1:0] r_data, g_data, b_data;
    logic unused_dn;

    assign unused_dn = ^{dn_addr[24:PROM_AW], dn_data[7:COL_W]};

    generate
        if (BG_DELAY == 0) begin : g_direct
            assign bg_dly = bg_pix;
        end else begin : g_delay
            pix_t dly_q [BG_DELAY];
            always_ff @(posedge master_clk) begin
                if (!reset_n) begin
                    dly_q <= '{default: '0};
                end else if (pixel_ce) begin
                    dly_q[0] <= bg_pix;
                    for (int i = 1; i < BG_DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign bg_dly = dly_q[BG_DELAY-1];
        end
    endgenerate

    assign idx_d = mix_index(bg_q, fg_q, spr_q, layer_en);

    // Blank flags reset to 1 so nothing stale reaches the screen until the pipe refills.
    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            bg_q        <= '0;
            fg_q        <= '0;
            spr_q       <= '0;
            idx_q       <= '0;
            blank_q     <= '1;
            blank_out_q <= 1'b1;
        end else if (pixel_ce) begin
            bg_q        <= bg_dly;
            fg_q        <= fg_pix;
            spr_q       <= spr_pix;
            idx_q       <= idx_d;
            blank_q     <= {blank_q[MIX_LATENCY-2:0], hblank | vblank};
            blank_out_q <= blank_q[MIX_LATENCY-1];
        end
    end

    colour_prom_256x4 #(.AW(PROM_AW)) u_prom_r (
        .clk(master_clk), .we_i(dn_wr & prom_r_cs), .waddr_i(dn_addr[PROM_AW-1:0]),
        .wdata_i(dn_data[COL_W-1:0]), .re_i(pixel_ce), .raddr_i(idx_q[PROM_AW-1:0]),
        .rdata_o(r_data)
    );
    colour_prom_256x4 #(.AW(PROM_AW)) u_prom_g (
        .clk(master_clk), .we_i(dn_wr & prom_g_cs), .waddr_i(dn_addr[PROM_AW-1:0]),
        .wdata_i(dn_data[COL_W-1:0]), .re_i(pixel_ce), .raddr_i(idx_q[PROM_AW-1:0]),
        .rdata_o(g_data)
    );
    colour_prom_256x4 #(.AW(PROM_AW)) u_prom_b (
        .clk(master_clk), .we_i(dn_wr & prom_b_cs), .waddr_i(dn_addr[PROM_AW-1:0]),
        .wdata_i(dn_data[COL_W-1:0]), .re_i(pixel_ce), .raddr_i(idx_q[PROM_AW-1:0]),
        .rdata_o(b_data)
    );

    assign red       = blank_out_q ? '0 : r_data;
    assign green     = blank_out_q ? '0 : g_data;
    assign blue      = blank_out_q ? '0 : b_data;
    assign blank_out = blank_out_q;
endmodule

// File: tb/tb_slap_video_mixer.sv
// tb_slap_video_mixer: scoreboard bench for two mixer instances (BG_DELAY 0 and 3) against
// a per-strobe history model of the layer rules and the downloaded colour tables.
module tb_slap_video_mixer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, pixel_ce, hblank, vblank, dn_wr, r_cs, g_cs, b_cs;
    logic [7:0] bg, fg, spr, dn_data;
    logic [2:0] layer_en;
    logic [24:0] dn_addr;
    logic [3:0] r0, g0, b0, r3, g3, b3;
    logic bo0, bo3;

    slap_video_mixer #(.BG_DELAY(0)) u_d0 (
        .master_clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .bg_pix(bg), .fg_pix(fg),
        .spr_pix(spr), .hblank(hblank), .vblank(vblank), .layer_en(layer_en), .dn_addr(dn_addr),
        .dn_data(dn_data), .dn_wr(dn_wr), .prom_r_cs(r_cs), .prom_g_cs(g_cs), .prom_b_cs(b_cs),
        .red(r0), .green(g0), .blue(b0), .blank_out(bo0)
    );
    slap_video_mixer #(.BG_DELAY(3)) u_d3 (
        .master_clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .bg_pix(bg), .fg_pix(fg),
        .spr_pix(spr), .hblank(hblank), .vblank(vblank), .layer_en(layer_en), .dn_addr(dn_addr),
        .dn_data(dn_data), .dn_wr(dn_wr), .prom_r_cs(r_cs), .prom_g_cs(g_cs), .prom_b_cs(b_cs),
        .red(r3), .green(g3), .blue(b3), .blank_out(bo3)
    );

    logic [3:0] mr [256], mg [256], mb [256];
    logic [7:0] bgh[$], fgh[$], sph[$];
    logic bh[$];
    logic [2:0] leh[$];
    logic [12:0] q0[$], q3[$];
    logic [12:0] last0, last3, e0, e3;
    int checks = 0, fails = 0;

    // Output after strobe n shows inputs of strobe n-2, BG of strobe n-2-d, layer_en of n-1.
    function automatic logic [12:0] expect_out(int d);
        int n = bgh.size() - 1;
        int s = n - 2;
        logic [7:0] b, idx;
        logic [2:0] le;
        if (s < 0) return {12'h000, 1'b1};
        if (bh[s]) return {12'h000, 1'b1};
        le = leh[n-1];
        b = (s - d >= 0) ? bgh[s-d] : 8'h00;
        if (fgh[s][1:0] != 2'b00 && le[2]) idx = fgh[s];
        else if (sph[s][3:0] != 4'h0 && le[1]) idx = sph[s];
        else idx = le[0] ? b : 8'h00;
        return {mr[idx], mg[idx], mb[idx], 1'b0};
    endfunction

    task automatic tick();
        if (!reset_n) begin
            bgh.delete(); fgh.delete(); sph.delete(); bh.delete(); leh.delete();
            last0 = {12'h000, 1'b1};
            last3 = {12'h000, 1'b1};
        end else if (pixel_ce) begin
            bgh.push_back(bg); fgh.push_back(fg); sph.push_back(spr);
            bh.push_back(hblank | vblank); leh.push_back(layer_en);
            last0 = expect_out(0);
            last3 = expect_out(3);
        end
        q0.push_back(last0);
        q3.push_back(last3);
        if (dn_wr) begin
            if (r_cs) mr[dn_addr[7:0]] = dn_data[3:0];
            if (g_cs) mg[dn_addr[7:0]] = dn_data[3:0];
            if (b_cs) mb[dn_addr[7:0]] = dn_data[3:0];
        end
        @(negedge clk);
    endtask

    task automatic pix(input logic [7:0] bv, input logic [7:0] fv, input logic [7:0] sv, input int n);
        bg = bv; fg = fv; spr = sv;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic prom_wr(input logic [2:0] cs, input logic [7:0] a, input logic [7:0] d);
        dn_wr = 1'b1; {r_cs, g_cs, b_cs} = cs;
        dn_addr = {17'($urandom), a}; dn_data = d;
        tick();
        dn_wr = 1'b0; {r_cs, g_cs, b_cs} = 3'b000;
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() == 0 || q3.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e0 = q0.pop_front();
            e3 = q3.pop_front();
            checks += 2;
            if ({r0, g0, b0, bo0} !== e0) begin
                fails++;
                $display("FAIL mix_d0 at %0t: got rgb=%h blank=%b, expected rgb=%h blank=%b",
                         $time, {r0, g0, b0}, bo0, e0[12:1], e0[0]);
            end
            if ({r3, g3, b3, bo3} !== e3) begin
                fails++;
                $display("FAIL mix_d3 at %0t: got rgb=%h blank=%b, expected rgb=%h blank=%b",
                         $time, {r3, g3, b3}, bo3, e3[12:1], e3[0]);
            end
        end
    end

    initial begin
        reset_n = 1'b0; pixel_ce = 1'b0; hblank = 1'b0; vblank = 1'b0;
        bg = '0; fg = '0; spr = '0; layer_en = 3'b111;
        dn_wr = 1'b0; r_cs = 1'b0; g_cs = 1'b0; b_cs = 1'b0; dn_addr = '0; dn_data = '0;
        for (int a = 0; a < 256; a++) begin
            mr[a] = 4'h0; mg[a] = 4'h0; mb[a] = 4'h0;
        end
        repeat (3) tick();
        // Multi-select write first, then G and B overwritten with their own tables.
        for (int a = 0; a < 256; a++) prom_wr(3'b111, 8'(a), {4'($urandom), 4'(a)});
        for (int a = 0; a < 256; a++) prom_wr(3'b010, 8'(a), {4'($urandom), 4'(a >> 4)});
        for (int a = 0; a < 256; a++) prom_wr(3'b001, 8'(a), {4'($urandom), 4'(~a)});
        reset_n = 1'b1; pixel_ce = 1'b1;
        pix(8'h35, 8'h00, 8'h00, 4);
        pix(8'h35, 8'h00, 8'h47, 3);
        pix(8'h35, 8'h91, 8'h47, 3);
        pix(8'h35, 8'hFC, 8'h12, 3);
        layer_en = 3'b110;
        pix(8'h35, 8'hFC, 8'h10, 3);
        layer_en = 3'b111;
        for (int i = 1; i <= 12; i++) pix(8'(i), 8'h00, 8'h00, 1);
        pix(8'h35, 8'h00, 8'h47, 3);
        hblank = 1'b1;
        pix(8'h35, 8'h00, 8'h47, 1);
        hblank = 1'b0;
        pix(8'h35, 8'h00, 8'h47, 3);
        pixel_ce = 1'b0;
        pix(8'h35, 8'h00, 8'h00, 4);
        prom_wr(3'b100, 8'h35, 8'h0C);
        pix(8'h35, 8'h00, 8'h00, 5);
        pixel_ce = 1'b1;
        pix(8'h35, 8'h00, 8'h00, 6);
        prom_wr(3'b100, 8'h35, 8'h03);
        pix(8'h35, 8'h00, 8'h00, 3);
        prom_wr(3'b100, 8'h35, 8'h0C);
        pix(8'h35, 8'h00, 8'h00, 3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        pix(8'h35, 8'h00, 8'h00, 5);
        for (int i = 0; i < 3000; i++) begin
            pixel_ce = ($urandom_range(3) != 0);
            bg = 8'($urandom);
            fg = 8'($urandom);
            if ($urandom_range(2) != 0) fg[1:0] = 2'b00;
            spr = 8'($urandom);
            if ($urandom_range(1) != 0) spr[3:0] = 4'h0;
            hblank = ($urandom_range(15) == 0);
            vblank = ($urandom_range(31) == 0);
            if ($urandom_range(63) == 0) layer_en = 3'($urandom);
            dn_wr = ($urandom_range(15) == 0);
            {r_cs, g_cs, b_cs} = 3'($urandom);
            dn_addr = 25'($urandom);
            dn_data = 8'($urandom);
            reset_n = ($urandom_range(199) != 0);
            tick();
        end
        reset_n = 1'b1; dn_wr = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
